// File: rtl/pgm_rd.sv
// pgm_rd: buffers PHVs, data beats and keep/discard verdicts from pgm, and
// forwards kept packets (PHV first, then beats, valid with the tail) to GOE.
// Optional build macro PGM_RD_DROP_CNT_EN enables the overflow drop counter;
// without it out_pgm_rd_drop_cnt is tied to 0.

// Synchronous FIFO with show-ahead head word and occupancy count.
module pgm_rd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [W-1:0]                 din,
  input  logic                         rd,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  // a write to a full FIFO is dropped so stored entries stay intact
  assign do_wr = wr && (cnt != CW'(DEPTH));
  assign do_rd = rd && (cnt != '0);
  assign dout  = mem[rd_ptr];

  // storage array, no reset needed: flush is done through the pointers
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

module pgm_rd #(
  parameter int DATA_DEPTH = 64,
  parameter int DATA_ALF   = 48,
  parameter int PHV_DEPTH  = 8,
  parameter int PHV_ALF    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] in_pgm_rd_phv,
  input  logic          in_pgm_rd_phv_wr,
  output logic          out_pgm_rd_phv_alf,
  input  logic [133:0]  in_pgm_rd_data,
  input  logic          in_pgm_rd_data_wr,
  input  logic          in_pgm_rd_valid,
  input  logic          in_pgm_rd_valid_wr,
  output logic          out_pgm_rd_alf,
  input  logic          in_pgm_rd_sent_start_flag,
  input  logic          in_pgm_rd_sent_finish_flag,
  output logic [1023:0] out_pgm_rd_phv,
  output logic          out_pgm_rd_phv_wr,
  input  logic          in_pgm_rd_phv_alf,
  output logic [133:0]  out_pgm_rd_data,
  output logic          out_pgm_rd_data_wr,
  output logic          out_pgm_rd_valid,
  output logic          out_pgm_rd_valid_wr,
  input  logic          in_pgm_rd_alf,
  output logic [31:0]   out_pgm_rd_pkt_cnt,
  output logic [15:0]   out_pgm_rd_drop_cnt
);
  localparam int DCW = $clog2(DATA_DEPTH+1);
  localparam int PCW = $clog2(PHV_DEPTH+1);

  typedef enum logic [1:0] {IDLE, SEND, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [133:0]    data_head;
  logic [1023:0]   phv_head;
  logic            vld_head;
  logic [DCW-1:0]  data_cnt;
  logic [PCW-1:0]  phv_cnt, vld_cnt;
  logic            data_empty, pkt_ready, tail_head;
  logic            data_pop, pkt_pop, fwd_phv, fwd_beat;
  logic            active;

  pgm_rd_fifo #(.W(134), .DEPTH(DATA_DEPTH)) u_data (
    .clk(clk), .rst(rst), .wr(in_pgm_rd_data_wr), .din(in_pgm_rd_data),
    .rd(data_pop), .dout(data_head), .cnt(data_cnt));

  pgm_rd_fifo #(.W(1024), .DEPTH(PHV_DEPTH)) u_phv (
    .clk(clk), .rst(rst), .wr(in_pgm_rd_phv_wr), .din(in_pgm_rd_phv),
    .rd(pkt_pop), .dout(phv_head), .cnt(phv_cnt));

  pgm_rd_fifo #(.W(1), .DEPTH(PHV_DEPTH)) u_vld (
    .clk(clk), .rst(rst), .wr(in_pgm_rd_valid_wr), .din(in_pgm_rd_valid),
    .rd(pkt_pop), .dout(vld_head), .cnt(vld_cnt));

  assign data_empty = (data_cnt == '0);
  assign pkt_ready  = (phv_cnt != '0) && (vld_cnt != '0);
  assign tail_head  = (data_head[133:132] == 2'b10);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and pop/forward decisions
  always_comb begin
    state_nxt = state;
    data_pop  = 1'b0;
    pkt_pop   = 1'b0;
    fwd_phv   = 1'b0;
    fwd_beat  = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_ready) begin
          if (vld_head) begin
            // only start a kept packet once GOE can take both PHV and data
            if (!in_pgm_rd_phv_alf && !in_pgm_rd_alf) begin
              pkt_pop   = 1'b1;
              fwd_phv   = 1'b1;
              state_nxt = SEND;
            end
          end else begin
            // dropped packet never touches GOE, so backpressure is irrelevant
            pkt_pop   = 1'b1;
            state_nxt = DISCARD;
          end
        end
      end
      SEND: begin
        if (!data_empty && !in_pgm_rd_alf) begin
          data_pop = 1'b1;
          fwd_beat = 1'b1;
          if (tail_head) state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (!data_empty) begin
          data_pop = 1'b1;
          if (tail_head) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // registered outputs toward GOE, one cycle behind the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pgm_rd_phv      <= '0;
      out_pgm_rd_phv_wr   <= 1'b0;
      out_pgm_rd_data     <= '0;
      out_pgm_rd_data_wr  <= 1'b0;
      out_pgm_rd_valid    <= 1'b0;
      out_pgm_rd_valid_wr <= 1'b0;
    end else begin
      out_pgm_rd_phv_wr   <= fwd_phv;
      out_pgm_rd_data_wr  <= fwd_beat;
      out_pgm_rd_valid    <= fwd_beat && tail_head;
      out_pgm_rd_valid_wr <= fwd_beat && tail_head;
      if (fwd_phv)  out_pgm_rd_phv  <= phv_head;
      if (fwd_beat) out_pgm_rd_data <= data_head;
    end
  end

  // almost-full flags back to pgm, registered from occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pgm_rd_alf     <= 1'b0;
      out_pgm_rd_phv_alf <= 1'b0;
    end else begin
      out_pgm_rd_alf     <= (data_cnt >= DCW'(DATA_ALF));
      out_pgm_rd_phv_alf <= (phv_cnt >= PCW'(PHV_ALF));
    end
  end

  // generation window and forwarded-packet counter; start wins over a tail
  always_ff @(posedge clk) begin
    if (rst) begin
      active             <= 1'b0;
      out_pgm_rd_pkt_cnt <= '0;
    end else if (in_pgm_rd_sent_start_flag) begin
      active             <= !in_pgm_rd_sent_finish_flag;
      out_pgm_rd_pkt_cnt <= '0;
    end else begin
      if (in_pgm_rd_sent_finish_flag) active <= 1'b0;
      if (active && fwd_beat && tail_head)
        out_pgm_rd_pkt_cnt <= out_pgm_rd_pkt_cnt + 32'd1;
    end
  end

`ifdef PGM_RD_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // saturating count of beats refused by a full data FIFO
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (in_pgm_rd_data_wr && (data_cnt == DCW'(DATA_DEPTH)) &&
             (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign out_pgm_rd_drop_cnt = drop_cnt;
`else
  assign out_pgm_rd_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pgm_rd.sv
// Scoreboard bench for pgm_rd: expected PHVs and beats are queued when
// written and popped by a negedge monitor when GOE strobes appear.
module tb_pgm_rd;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1023:0] in_pgm_rd_phv = '0;
  logic          in_pgm_rd_phv_wr = 1'b0;
  logic          out_pgm_rd_phv_alf;
  logic [133:0]  in_pgm_rd_data = '0;
  logic          in_pgm_rd_data_wr = 1'b0;
  logic          in_pgm_rd_valid = 1'b0;
  logic          in_pgm_rd_valid_wr = 1'b0;
  logic          out_pgm_rd_alf;
  logic          in_pgm_rd_sent_start_flag = 1'b0;
  logic          in_pgm_rd_sent_finish_flag = 1'b0;
  logic [1023:0] out_pgm_rd_phv;
  logic          out_pgm_rd_phv_wr;
  logic          in_pgm_rd_phv_alf = 1'b0;
  logic [133:0]  out_pgm_rd_data;
  logic          out_pgm_rd_data_wr;
  logic          out_pgm_rd_valid;
  logic          out_pgm_rd_valid_wr;
  logic          in_pgm_rd_alf = 1'b0;
  logic [31:0]   out_pgm_rd_pkt_cnt;
  logic [15:0]   out_pgm_rd_drop_cnt;

`ifdef PGM_RD_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd6;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  always #5 clk = ~clk;

  pgm_rd dut (
    .clk(clk), .rst(rst),
    .in_pgm_rd_phv(in_pgm_rd_phv), .in_pgm_rd_phv_wr(in_pgm_rd_phv_wr),
    .out_pgm_rd_phv_alf(out_pgm_rd_phv_alf),
    .in_pgm_rd_data(in_pgm_rd_data), .in_pgm_rd_data_wr(in_pgm_rd_data_wr),
    .in_pgm_rd_valid(in_pgm_rd_valid), .in_pgm_rd_valid_wr(in_pgm_rd_valid_wr),
    .out_pgm_rd_alf(out_pgm_rd_alf),
    .in_pgm_rd_sent_start_flag(in_pgm_rd_sent_start_flag),
    .in_pgm_rd_sent_finish_flag(in_pgm_rd_sent_finish_flag),
    .out_pgm_rd_phv(out_pgm_rd_phv), .out_pgm_rd_phv_wr(out_pgm_rd_phv_wr),
    .in_pgm_rd_phv_alf(in_pgm_rd_phv_alf),
    .out_pgm_rd_data(out_pgm_rd_data), .out_pgm_rd_data_wr(out_pgm_rd_data_wr),
    .out_pgm_rd_valid(out_pgm_rd_valid), .out_pgm_rd_valid_wr(out_pgm_rd_valid_wr),
    .in_pgm_rd_alf(in_pgm_rd_alf),
    .out_pgm_rd_pkt_cnt(out_pgm_rd_pkt_cnt), .out_pgm_rd_drop_cnt(out_pgm_rd_drop_cnt));

  logic [1023:0] phv_q [$];
  logic [133:0]  data_q [$];
  logic [1023:0] exp_phv;
  logic [133:0]  exp_data;
  int tests = 0, fails = 0;
  int phv_seen = 0, data_seen = 0, valid_seen = 0;
  bit sb_on = 1'b1;
  logic [31:0] exp_pkt = '0;

  // monitor: pops the scoreboard on every GOE strobe
  always @(negedge clk) begin
    if (out_pgm_rd_phv_wr) begin
      phv_seen++;
      if (sb_on) begin
        tests++;
        if (phv_q.size() == 0) begin
          fails++; $display("FAIL phv_unexpected got=%h", out_pgm_rd_phv[63:0]);
        end else begin
          exp_phv = phv_q.pop_front();
          if (out_pgm_rd_phv !== exp_phv) begin
            fails++; $display("FAIL phv_order got=%h exp=%h", out_pgm_rd_phv[127:0], exp_phv[127:0]);
          end
        end
      end
    end
    if (out_pgm_rd_data_wr) begin
      data_seen++;
      if (sb_on) begin
        tests++;
        if (data_q.size() == 0) begin
          fails++; $display("FAIL beat_unexpected got=%h", out_pgm_rd_data);
        end else begin
          exp_data = data_q.pop_front();
          if (out_pgm_rd_data !== exp_data) begin
            fails++; $display("FAIL beat_order got=%h exp=%h", out_pgm_rd_data, exp_data);
          end
        end
      end
    end
    if (out_pgm_rd_valid_wr) begin
      valid_seen++;
      if (sb_on) begin
        tests++;
        if ({out_pgm_rd_valid, out_pgm_rd_data_wr, out_pgm_rd_data[133:132]} !== 4'b1110) begin
          fails++; $display("FAIL valid_with_tail got=%b exp=1110",
                            {out_pgm_rd_valid, out_pgm_rd_data_wr, out_pgm_rd_data[133:132]});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [133:0] mk_beat(input logic [1:0] t);
    return {t, $urandom, $urandom, $urandom, $urandom, 4'h0};
  endfunction

  function automatic logic [1023:0] mk_phv();
    logic [1023:0] p;
    for (int i = 0; i < 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic wr_beat(input logic [133:0] d);
    in_pgm_rd_data = d; in_pgm_rd_data_wr = 1'b1; tick(); in_pgm_rd_data_wr = 1'b0;
  endtask

  task automatic wr_phv(input logic [1023:0] p);
    in_pgm_rd_phv = p; in_pgm_rd_phv_wr = 1'b1; tick(); in_pgm_rd_phv_wr = 1'b0;
  endtask

  task automatic wr_valid(input logic v);
    in_pgm_rd_valid = v; in_pgm_rd_valid_wr = 1'b1; tick(); in_pgm_rd_valid_wr = 1'b0;
  endtask

  // PHV, then n beats (01,11..,10), then the verdict
  task automatic send_pkt(input int n, input logic v);
    logic [1023:0] p;
    logic [133:0] d;
    p = mk_phv();
    wr_phv(p);
    if (v) phv_q.push_back(p);
    for (int i = 0; i < n; i++) begin
      d = mk_beat(i == 0 ? 2'b01 : (i == n-1 ? 2'b10 : 2'b11));
      if (v) data_q.push_back(d);
      wr_beat(d);
    end
    wr_valid(v);
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (phv_q.size() == 0 && data_q.size() == 0) break;
    end
    tests++;
    if (i == 1000) begin
      fails++; $display("FAIL %s_drain left=%0d exp=0", name, data_q.size() + phv_q.size());
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
    tests++;
    if ({out_pgm_rd_phv_wr, out_pgm_rd_data_wr, out_pgm_rd_valid_wr, out_pgm_rd_valid} !== 4'b0) begin
      fails++; $display("FAIL reset_strobes got=%b exp=0000",
        {out_pgm_rd_phv_wr, out_pgm_rd_data_wr, out_pgm_rd_valid_wr, out_pgm_rd_valid});
    end
    tests++;
    if ({out_pgm_rd_alf, out_pgm_rd_phv_alf} !== 2'b0) begin
      fails++; $display("FAIL reset_alf got=%b exp=00", {out_pgm_rd_alf, out_pgm_rd_phv_alf});
    end
    tests++;
    if ({out_pgm_rd_pkt_cnt, out_pgm_rd_drop_cnt} !== 48'h0) begin
      fails++; $display("FAIL reset_counters got=%h exp=0", {out_pgm_rd_pkt_cnt, out_pgm_rd_drop_cnt});
    end
    tests++;
    if ({out_pgm_rd_phv, out_pgm_rd_data} !== '0) begin
      fails++; $display("FAIL reset_buses got=%h exp=0", out_pgm_rd_data);
    end
  endtask

  task automatic test_basic();
    int bp, bd, bv;
    in_pgm_rd_sent_start_flag = 1'b1; tick(); in_pgm_rd_sent_start_flag = 1'b0;
    exp_pkt = 0;
    bp = phv_seen; bd = data_seen; bv = valid_seen;
    send_pkt(4, 1'b1);
    exp_pkt++;
    wait_drain("basic");
    tests++;
    if (out_pgm_rd_pkt_cnt !== exp_pkt) begin
      fails++; $display("FAIL basic_pkt_cnt got=%0d exp=%0d", out_pgm_rd_pkt_cnt, exp_pkt);
    end
    tests++;
    if ({phv_seen - bp, data_seen - bd, valid_seen - bv} !== {32'd1, 32'd4, 32'd1}) begin
      fails++; $display("FAIL basic_strobes got=%0d/%0d/%0d exp=1/4/1", phv_seen-bp, data_seen-bd, valid_seen-bv);
    end
  endtask

  task automatic test_discard();
    int bp, bd, bv;
    bp = phv_seen; bd = data_seen; bv = valid_seen;
    send_pkt(3, 1'b0);
    repeat (20) tick();
    tests++;
    if ({phv_seen - bp, data_seen - bd, valid_seen - bv} !== 96'd0) begin
      fails++; $display("FAIL discard_strobes got=%0d/%0d/%0d exp=0/0/0", phv_seen-bp, data_seen-bd, valid_seen-bv);
    end
    tests++;
    if (out_pgm_rd_pkt_cnt !== exp_pkt) begin
      fails++; $display("FAIL discard_pkt_cnt got=%0d exp=%0d", out_pgm_rd_pkt_cnt, exp_pkt);
    end
    send_pkt(5, 1'b1);
    exp_pkt++;
    wait_drain("after_discard");
    tests++;
    if (data_seen - bd !== 5) begin
      fails++; $display("FAIL after_discard_beats got=%0d exp=5", data_seen - bd);
    end
    tests++;
    if (out_pgm_rd_pkt_cnt !== exp_pkt) begin
      fails++; $display("FAIL after_discard_pkt_cnt got=%0d exp=%0d", out_pgm_rd_pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_alf_stall();
    int bd, lows, i;
    bd = data_seen;
    send_pkt(8, 1'b1);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_seen >= bd + 2) break;
    end
    tests++;
    if (i == 200) begin
      fails++; $display("FAIL stall_start got=%0d exp=2", data_seen - bd);
    end
    tick();
    in_pgm_rd_alf = 1'b1;
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!out_pgm_rd_data_wr) lows++;
      tick();
      if (k == 4) in_pgm_rd_alf = 1'b0;
    end
    exp_pkt++;
    wait_drain("stall");
    tests++;
    if (lows !== 5) begin
      fails++; $display("FAIL stall_low_cycles got=%0d exp=5", lows);
    end
    tests++;
    if (data_seen - bd !== 8) begin
      fails++; $display("FAIL stall_beats got=%0d exp=8", data_seen - bd);
    end
  endtask

  task automatic test_overflow();
    int bd;
    logic [133:0] d;
    logic [1023:0] p;
    bd = data_seen;
    in_pgm_rd_alf = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = mk_beat(i == 0 ? 2'b01 : (i == 63 ? 2'b10 : 2'b11));
      data_q.push_back(d);
      wr_beat(d);
      if (i == 46 || i == 47) begin
        tick(); tick();
        tests++;
        if (out_pgm_rd_alf !== (i == 47)) begin
          fails++; $display("FAIL alf_at_%0d got=%b exp=%b", i + 1, out_pgm_rd_alf, (i == 47));
        end
      end
    end
    for (int i = 0; i < 6; i++) wr_beat(mk_beat(2'b11));
    tests++;
    if (out_pgm_rd_drop_cnt !== EXP_DROP) begin
      fails++; $display("FAIL drop_cnt got=%0d exp=%0d", out_pgm_rd_drop_cnt, EXP_DROP);
    end
    tests++;
    if (data_seen != bd) begin
      fails++; $display("FAIL overflow_held got=%0d exp=0", data_seen - bd);
    end
    p = mk_phv();
    phv_q.push_back(p);
    wr_phv(p);
    wr_valid(1'b1);
    repeat (3) tick();
    in_pgm_rd_alf = 1'b0;
    exp_pkt++;
    wait_drain("overflow");
    tests++;
    if (data_seen - bd !== 64) begin
      fails++; $display("FAIL overflow_beats got=%0d exp=64", data_seen - bd);
    end
    tests++;
    if ({out_pgm_rd_alf, out_pgm_rd_pkt_cnt} !== {1'b0, exp_pkt}) begin
      fails++; $display("FAIL overflow_after alf=%b cnt=%0d exp alf=0 cnt=%0d", out_pgm_rd_alf, out_pgm_rd_pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_window_same();
    int bd;
    in_pgm_rd_sent_start_flag = 1'b1; in_pgm_rd_sent_finish_flag = 1'b1; tick();
    in_pgm_rd_sent_start_flag = 1'b0; in_pgm_rd_sent_finish_flag = 1'b0;
    exp_pkt = 0;
    bd = data_seen;
    send_pkt(4, 1'b1);
    wait_drain("window");
    tests++;
    if (out_pgm_rd_pkt_cnt !== exp_pkt) begin
      fails++; $display("FAIL window_pkt_cnt got=%0d exp=%0d", out_pgm_rd_pkt_cnt, exp_pkt);
    end
    tests++;
    if (data_seen - bd !== 4) begin
      fails++; $display("FAIL window_beats got=%0d exp=4", data_seen - bd);
    end
  endtask

  task automatic test_phv_alf();
    for (int i = 0; i < 6; i++) begin
      wr_phv(mk_phv());
      if (i >= 4) begin
        tick(); tick();
        tests++;
        if (out_pgm_rd_phv_alf !== (i == 5)) begin
          fails++; $display("FAIL phv_alf_at_%0d got=%b exp=%b", i + 1, out_pgm_rd_phv_alf, (i == 5));
        end
      end
    end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    tests++;
    if (out_pgm_rd_phv_alf !== 1'b0) begin
      fails++; $display("FAIL phv_alf_reset got=%b exp=0", out_pgm_rd_phv_alf);
    end
  endtask

  task automatic test_mid_reset();
    int bd, bp, bv, i;
    in_pgm_rd_sent_start_flag = 1'b1; tick(); in_pgm_rd_sent_start_flag = 1'b0;
    sb_on = 1'b0;
    bd = data_seen;
    wr_phv(mk_phv());
    wr_valid(1'b1);
    wr_beat(mk_beat(2'b01));
    wr_beat(mk_beat(2'b11));
    for (i = 0; i < 50; i++) begin
      if (data_seen >= bd + 1) break;
      tick();
    end
    tests++;
    if (i == 50) begin
      fails++; $display("FAIL midrst_first_beat got=%0d exp=1", data_seen - bd);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++;
    if ({out_pgm_rd_phv_wr, out_pgm_rd_data_wr, out_pgm_rd_valid_wr, out_pgm_rd_valid,
         out_pgm_rd_alf, out_pgm_rd_phv_alf} !== 6'b0) begin
      fails++; $display("FAIL midrst_flags got=%b exp=000000", {out_pgm_rd_phv_wr, out_pgm_rd_data_wr,
        out_pgm_rd_valid_wr, out_pgm_rd_valid, out_pgm_rd_alf, out_pgm_rd_phv_alf});
    end
    tests++;
    if ({out_pgm_rd_pkt_cnt, out_pgm_rd_drop_cnt} !== 48'h0) begin
      fails++; $display("FAIL midrst_counters got=%h exp=0", {out_pgm_rd_pkt_cnt, out_pgm_rd_drop_cnt});
    end
    tests++;
    if ({out_pgm_rd_phv, out_pgm_rd_data} !== '0) begin
      fails++; $display("FAIL midrst_buses got=%h exp=0", out_pgm_rd_data);
    end
    bp = phv_seen; bd = data_seen; bv = valid_seen;
    wr_beat(mk_beat(2'b11));
    wr_beat(mk_beat(2'b10));
    repeat (20) tick();
    tests++;
    if ({phv_seen - bp, data_seen - bd, valid_seen - bv, out_pgm_rd_pkt_cnt} !== 128'd0) begin
      fails++; $display("FAIL midrst_quiet got=%0d/%0d/%0d cnt=%0d exp=0/0/0 cnt=0",
        phv_seen-bp, data_seen-bd, valid_seen-bv, out_pgm_rd_pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_alf_stall();
    test_overflow();
    test_window_same();
    test_phv_alf();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
